multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle RV32I control FSM: sequences one shared ALU, one unified instr/data memory and the
//  register file over several cycles per instruction. Replaces single-cycle decode for the
//  multicycle datapath. Adds a memory-ready handshake so the datapath stalls on slow memory.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMREAD/MEMWRITE wait for MemReady; 0: MemReady ignored (treated 1)
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  op          in   7  instruction opcode (IR[6:0])
//  funct3      in   3  IR[14:12]
//  funct7b5    in   1  IR[30]
//  LogOut      in   1  branch condition from comparator (1 = taken)
//  MemReady    in   1  memory access completes this cycle
//  PCWrite     out  1  PC register enable
//  AdrSrc      out  1  memory address: 0=PC, 1=ALUOut
//  MemWrite    out  1  memory write enable
//  IRWrite     out  1  instruction/OldPC register enable
//  ResultSrc   out  2  00=ALUOut 01=Data 10=ALUResult 11=ImmExt
//  ALUSrcA     out  2  00=PC 01=OldPC 10=RD1
//  ALUSrcB     out  2  00=RD2 01=ImmExt 10=const 4
//  RegWrite    out  1  register file write enable
//  ImmSrc      out  3  000=I 001=S 010=B 011=J 100=U
//  ALUControl  out  4  0000 add,0001 sub,0010 and,0011 or,0100 xor,0101 slt,0110 sltu,0111 sll,1000 srl,1001 sra
//  Illegal     out  1  one-cycle pulse: unsupported opcode seen in DECODE
// BEHAVIOUR
//  - Async reset -> state FETCH. While reset high: PCWrite/IRWrite/MemWrite/RegWrite/Illegal = 0;
//    other outputs take their FETCH values.
//  - Moore outputs per state (unlisted = 0; ALUOp 00=add, 01=sub, 10=funct decode):
//    FETCH   : AdrSrc0, SrcA00, SrcB10, add, Res10; IRWrite=PCWrite=MemReady -> DECODE when MemReady
//    DECODE  : SrcA01, SrcB01, add (branch/jump target to ALUOut); next by op:
//              0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//              1101111->JAL, 0110111->LUI, other->FETCH with Illegal=1
//    MEMADR  : SrcA10, SrcB01, add -> MEMREAD if op[5]=0 else MEMWRITE
//    MEMREAD : AdrSrc1, Res00; stay until MemReady -> MEMWB
//    MEMWB   : Res01, RegWrite -> FETCH
//    MEMWRITE: AdrSrc1, Res00, MemWrite held high; stay until MemReady -> FETCH
//    EXECR   : SrcA10, SrcB00, ALUOp10 -> ALUWB;  EXECI: SrcA10, SrcB01, ALUOp10 -> ALUWB
//    ALUWB   : Res00, RegWrite -> FETCH
//    BRANCH  : SrcA10, SrcB00, sub, Res00; PCWrite = LogOut (Mealy) -> FETCH
//    JAL     : SrcA01, SrcB10, add, Res00, PCWrite -> ALUWB (rd = OldPC+4)
//    LUI     : Res11, RegWrite -> FETCH
//  - ImmSrc: combinational from op (lw/ALU-I->000, sw->001, branch->010, jal->011, lui->100, else 000).
//  - ALUOp10 decode on funct3: 000 add (sub if op[5]&funct7b5), 001 sll, 010 slt, 011 sltu,
//    100 xor, 101 srl/sra by funct7b5, 110 or, 111 and. funct7b5 ignored for I-type add.
//  - CPI: lw 5, sw 4, R/I 4, branch 3, jal 4, lui 3 (+ memory wait cycles).
//  - MemReady low in FETCH: outputs held, no enables, no state change. Reset mid-instruction
//    aborts immediately; no partial register or memory write is issued after reset asserts.
// TESTING
//  - reset high mid-MEMWRITE -> MemWrite drops 0 same cycle; after release FETCH, IRWrite=1 with MemReady=1
//  - add x3,x1,x2 (op 0110011,f3 000,f7b5 0), MemReady=1 -> FETCH,DECODE,EXECR(ALUControl 0000),ALUWB RegWrite=1
//  - sub (f7b5 1) -> ALUControl 0001; addi with IR[30]=1 -> ALUControl 0000
//  - lw with MemReady low 3 cycles in MEMREAD -> stays 3 extra cycles, RegWrite only in MEMWB, total 8
//  - beq LogOut=0 -> PCWrite 0 in BRANCH; LogOut=1 -> PCWrite 1 exactly one cycle
//  - op 1111111 -> Illegal pulses 1 cycle in DECODE, next state FETCH, no writes

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences the shared ALU, the unified memory and the register file.
// It stalls on MemReady in FETCH, MEMREAD and MEMWRITE unless MEM_HANDSHAKE is 0.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       LogOut,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, LUI
  } state_t;

  state_t     state, state_next;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  assign mem_ready = MemReady | ~MEM_HANDSHAKE;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next state and per-state datapath controls.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Precompute PC-relative target into ALUOut for branch/jal.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXECR;
          OP_I:              state_next = EXECI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_LUI:            state_next = LUI;
          default: begin
            state_next = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = ALUOP_SUB;
        pc_write   = LogOut;
        state_next = FETCH;
      end
      JAL: begin
        // Redirect PC from ALUOut while computing the link value OldPC+4.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // ALU operation select; funct7b5 only distinguishes sub for R-type.
  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
    endcase
  end

  // Immediate format from opcode.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_JAL:    ImmSrc = 3'b011;
      OP_LUI:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  // Enables are forced low while reset is held.
  assign PCWrite   = pc_write & ~reset;
  assign IRWrite   = ir_write & ~reset;
  assign MemWrite  = mem_write & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign Illegal   = illegal_op & ~reset;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each driven cycle queues hand-computed outputs,
// and a negedge monitor pops and compares them.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       rw;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  v;
  } exp_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = OP_R;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       LogOut = 1'b0;
  logic       MemReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   done = 1'b0;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .LogOut(LogOut), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  function automatic ctl_t c(input logic pcw, input logic adr, input logic mw, input logic irw,
                             input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                             input logic rw, input logic [2:0] imm, input logic [3:0] alu,
                             input logic ill);
    ctl_t t;
    t = '{pcw, adr, mw, irw, res, sa, sb, rw, imm, alu, ill};
    return t;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
  task automatic cyc(input string name, input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic lo, input logic mr, input ctl_t e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; op = o; funct3 = f3; funct7b5 = f7; LogOut = lo; MemReady = mr;
    x.name = name;
    x.v = e;
    q.push_back(x);
    pushed++;
  endtask

  initial begin
    // reset held: FETCH values, enables low
    cyc("rst0", 1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("rst1", 1'b1, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    // add x3,x1,x2
    cyc("add_fetch",  1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("add_decode", 1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("add_execr",  1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b000,4'b0000,1'b0));
    cyc("add_aluwb",  1'b0, OP_R, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    // sub
    cyc("sub_fetch",  1'b0, OP_R, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("sub_decode", 1'b0, OP_R, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("sub_execr",  1'b0, OP_R, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b000,4'b0001,1'b0));
    cyc("sub_aluwb",  1'b0, OP_R, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    // addi with IR[30]=1 stays add
    cyc("addi_fetch",  1'b0, OP_I, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("addi_decode", 1'b0, OP_I, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("addi_execi",  1'b0, OP_I, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("addi_aluwb",  1'b0, OP_I, 3'b000, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    // sra (R), xori, and (R): only the exec cycle differs
    cyc("sra_fetch",  1'b0, OP_R, 3'b101, 1'b1, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("sra_decode", 1'b0, OP_R, 3'b101, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("sra_execr",  1'b0, OP_R, 3'b101, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b000,4'b1001,1'b0));
    cyc("sra_aluwb",  1'b0, OP_R, 3'b101, 1'b1, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    cyc("xori_fetch",  1'b0, OP_I, 3'b100, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("xori_decode", 1'b0, OP_I, 3'b100, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("xori_execi",  1'b0, OP_I, 3'b100, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b000,4'b0100,1'b0));
    cyc("xori_aluwb",  1'b0, OP_I, 3'b100, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    cyc("and_fetch",  1'b0, OP_R, 3'b111, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("and_decode", 1'b0, OP_R, 3'b111, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("and_execr",  1'b0, OP_R, 3'b111, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b000,4'b0010,1'b0));
    cyc("and_aluwb",  1'b0, OP_R, 3'b111, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    // lw with three wait cycles in MEMREAD: 8 cycles total
    cyc("lw_fetch",  1'b0, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("lw_decode", 1'b0, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b0));
    cyc("lw_memadr", 1'b0, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b000,4'b0000,1'b0));
    for (int i = 0; i < 3; i++)
      cyc("lw_memread_wait", 1'b0, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, c(1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,3'b000,4'b0000,1'b0));
    cyc("lw_memread", 1'b0, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,3'b000,4'b0000,1'b0));
    cyc("lw_memwb",   1'b0, OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b1,3'b000,4'b0000,1'b0));
    // sw with FETCH stall and one MEMWRITE wait
    cyc("sw_fetch_stall0", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, c(1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,3'b001,4'b0000,1'b0));
    cyc("sw_fetch_stall1", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, c(1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,3'b001,4'b0000,1'b0));
    cyc("sw_fetch",  1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b001,4'b0000,1'b0));
    cyc("sw_decode", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b001,4'b0000,1'b0));
    cyc("sw_memadr", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b001,4'b0000,1'b0));
    cyc("sw_memwrite_wait", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, c(1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,3'b001,4'b0000,1'b0));
    cyc("sw_memwrite",      1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,3'b001,4'b0000,1'b0));
    // beq not taken, then taken
    cyc("beqn_fetch",  1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b010,4'b0000,1'b0));
    cyc("beqn_decode", 1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b010,4'b0000,1'b0));
    cyc("beqn_branch", 1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b010,4'b0001,1'b0));
    cyc("beqt_fetch",  1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b010,4'b0000,1'b0));
    cyc("beqt_decode", 1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b010,4'b0000,1'b0));
    cyc("beqt_branch", 1'b0, OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1, c(1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,3'b010,4'b0001,1'b0));
    cyc("beqt_after",  1'b0, OP_JAL, 3'b000, 1'b0, 1'b1, 1'b0, c(1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,3'b011,4'b0000,1'b0));
    // jal
    cyc("jal_fetch",  1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b011,4'b0000,1'b0));
    cyc("jal_decode", 1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b011,4'b0000,1'b0));
    cyc("jal_jal",    1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,1'b0,3'b011,4'b0000,1'b0));
    cyc("jal_aluwb",  1'b0, OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,3'b011,4'b0000,1'b0));
    // lui
    cyc("lui_fetch",  1'b0, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b100,4'b0000,1'b0));
    cyc("lui_decode", 1'b0, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b100,4'b0000,1'b0));
    cyc("lui_lui",    1'b0, OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,3'b100,4'b0000,1'b0));
    // illegal opcode
    cyc("ill_fetch",  1'b0, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b000,4'b0000,1'b0));
    cyc("ill_decode", 1'b0, OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b000,4'b0000,1'b1));
    // sw aborted by reset mid-MEMWRITE
    cyc("rsw_fetch",  1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b001,4'b0000,1'b0));
    cyc("rsw_decode", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b001,4'b0000,1'b0));
    cyc("rsw_memadr", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,1'b0,3'b001,4'b0000,1'b0));
    cyc("rsw_memwrite", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, c(1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,3'b001,4'b0000,1'b0));
    cyc("rsw_reset",    1'b1, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,1'b0,3'b001,4'b0000,1'b0));
    cyc("rsw_refetch",  1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,1'b0,3'b001,4'b0000,1'b0));
    cyc("rsw_redecode", 1'b0, OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, c(1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,1'b0,3'b001,4'b0000,1'b0));
    done = 1'b1;
  end

  // Monitor: every cycle's outputs are presented at the falling edge.
  initial begin
    exp_t e;
    ctl_t got;
    while (!done || q.size() > 0) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        popped++;
        got = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, Illegal};
        checks++;
        if (got !== e.v) begin
          fails++;
          $display("FAIL %s: got pcw=%b adr=%b mw=%b irw=%b res=%b sa=%b sb=%b rw=%b imm=%b alu=%b ill=%b, want pcw=%b adr=%b mw=%b irw=%b res=%b sa=%b sb=%b rw=%b imm=%b alu=%b ill=%b",
                   e.name, got.pcw, got.adr, got.mw, got.irw, got.res, got.sa, got.sb, got.rw, got.imm, got.alu, got.ill,
                   e.v.pcw, e.v.adr, e.v.mw, e.v.irw, e.v.res, e.v.sa, e.v.sb, e.v.rw, e.v.imm, e.v.alu, e.v.ill);
        end
      end
    end
    checks++;
    if (popped != pushed) begin
      fails++;
      $display("FAIL scoreboard_drain: popped %0d, pushed %0d", popped, pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: run did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
